dmem_access_controller: RTL and testbench

- Load/store sequencer between the pipeline MEM stage and the 256x32 word-wide data memory.
- Decodes RV32IM func3 and checks alignment and range.
- Performs byte/halfword lane extraction with sign or zero extension on loads.
- Memory is word-only with no byte enables, so SB/SH are done as read-modify-write.
- Drives the memory request/ack handshake, stalls the pipeline via busywait, and reports errors plus timeout.

---
 rtl/dmem_access_controller_pkg.sv | 39 +++
 rtl/dmem_access_controller_lane_align.sv | 49 ++++
 rtl/dmem_access_controller.sv | 163 ++++++++++++++++
 tb/tb_dmem_access_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_controller_pkg.sv
// Shared definitions for the data-memory access controller: func3 codes,
// FSM states, error codes and the request legality check.
package dmem_access_controller_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_t;

  // Illegal (both directions, bad func3, out of range) outranks misalignment.
  function automatic err_t check_req(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic range_ok,
                                     input logic [1:0] off);
    logic legal_f3;
    legal_f3 = rd ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                  : (f3 inside {F3_B, F3_H, F3_W});
    if ((rd && wr) || !legal_f3 || !range_ok) return ERR_ILLEGAL;
    if ((f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00)) return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_access_controller_lane_align.sv
// Byte/halfword lane handling: load extraction with extension, and the
// store merge used by the read-modify-write path.
module dmem_lane_align
  import dmem_access_controller_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: r[{off, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    load_o  = load_extend(rdata_i, off_i, func3_i);
    merge_o = store_merge(rdata_i, wdata_i, off_i, func3_i);
  end

endmodule

// File: rtl/dmem_access_controller.sv
// Load/store sequencer between the MEM stage and a word-only data memory;
// sub-word stores are performed as read-modify-write.
module dmem_access_controller
  import dmem_access_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic                  cpu_busywait,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_done,
  output logic [1:0]            cpu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_q, req_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  err_t                  err_q, err_d, chk_err;
  logic [2:0]            func3_q, func3_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           load_data, merge_data;

  dmem_lane_align u_lane (
    .rdata_i (mem_rdata),
    .wdata_i (wdata_q),
    .off_i   (off_q),
    .func3_i (func3_q),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    func3_d = func3_q;
    off_d   = off_q;
    chk_err = check_req(cpu_read, cpu_write, cpu_func3,
                        cpu_addr[31:ADDR_WIDTH+2] == '0, cpu_addr[1:0]);

    case (state_q)
      S_IDLE: begin
        if (cpu_read || cpu_write) begin
          func3_d = cpu_func3;
          off_d   = cpu_addr[1:0];
          rdata_d = '0;
          err_d   = chk_err;
          if (chk_err != ERR_NONE) begin
            state_d = S_RESP;
          end else begin
            addr_d  = cpu_addr[ADDR_WIDTH+1:2];
            wdata_d = cpu_wdata;
            req_d   = 1'b1;
            we_d    = cpu_write && (cpu_func3 == F3_W);
            if (cpu_read)                state_d = S_RD;
            else if (cpu_func3 == F3_W)  state_d = S_WR;
            else                         state_d = S_RMW_RD;
          end
        end
      end
      S_RD: if (mem_ack) begin
        rdata_d = load_data;
        req_d   = 1'b0;
        state_d = S_RESP;
      end
      S_WR: if (mem_ack) begin
        req_d   = 1'b0;
        state_d = S_RESP;
      end
      // Request drops for one registered cycle before the write phase.
      S_RMW_RD: if (mem_ack) begin
        wdata_d = merge_data;
        req_d   = 1'b0;
        we_d    = 1'b1;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Only cycles with the request raised count as waiting; ack wins a tie.
    if (req_q && state_q != S_IDLE && state_q != S_RESP && !mem_ack) begin
      if (cnt_q == CNT_LAST) begin
        req_d   = 1'b0;
        err_d   = ERR_TIMEOUT;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
      func3_q <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      func3_q <= func3_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    cpu_busywait = ((state_q == S_IDLE) && (cpu_read || cpu_write)) ||
                   (state_q inside {S_RD, S_WR, S_RMW_RD, S_RMW_WR});
    cpu_done  = (state_q == S_RESP);
    cpu_rdata = rdata_q;
    cpu_err   = err_q;
    mem_req   = req_q;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_dmem_access_controller.sv
// Directed bench for dmem_access_controller with a behavioural word memory
// whose ack latency is set per transaction.
module tb_dmem_access_controller;
  import dmem_access_controller_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0]  cpu_func3 = '0;
  logic        cpu_busywait, cpu_done, mem_req, mem_we;
  logic [31:0] cpu_rdata, mem_wdata;
  logic [1:0]  cpu_err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  dmem_access_controller #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3),
    .cpu_busywait(cpu_busywait), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int ack_delay = 0, req_cycles = 0, writes = 0;
  logic stray_ack = 1'b0;

  // Ack decided in the low phase so it is seen at the next rising edge.
  always @(negedge clk) begin
    if (mem_req) begin
      if (req_cycles == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          writes++;
        end
      end else begin
        mem_ack = 1'b0;
      end
      req_cycles++;
    end else begin
      mem_ack    = stray_ack;
      req_cycles = 0;
    end
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, init;
    int          delay;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          busy, phases, reqcyc, nwr;
    logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] init, int delay,
                              logic [31:0] exp_rdata, logic [1:0] exp_err, int busy,
                              int phases, int reqcyc, int nwr, logic [31:0] exp_word);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.init = init;
    v.delay = delay; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.busy = busy;
    v.phases = phases; v.reqcyc = reqcyc; v.nwr = nwr; v.exp_word = exp_word;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int busy = 0, phases = 0, reqcyc = 0, dones = 0;
    logic prev = 1'b0, got = 1'b0, fw = 1'b0;
    logic [7:0]  fa = '0;
    logic [7:0]  wi;
    logic [31:0] rdv = '0;
    logic [1:0]  erv = '0;
    string nm;
    nm = $sformatf("v%0d", idx);
    wi = v.addr[9:2];
    @(negedge clk);
    mem[wi] = v.init; ack_delay = v.delay; writes = 0;
    cpu_read = v.rd; cpu_write = v.wr; cpu_addr = v.addr;
    cpu_wdata = v.wdata; cpu_func3 = v.f3;
    for (int c = 0; c < 300 && !got; c++) begin
      #1;
      if (cpu_busywait) busy++;
      if (mem_req) begin
        reqcyc++;
        if (!prev) begin
          phases++;
          if (phases == 1) begin fa = mem_addr; fw = mem_we; end
        end
      end
      prev = mem_req;
      if (cpu_done) begin
        got = 1'b1; dones++; rdv = cpu_rdata; erv = cpu_err;
        cpu_read = 1'b0; cpu_write = 1'b0;
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      if (cpu_done) dones++;
      if (mem_req) reqcyc++;
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_done_pulses"}, dones, 1);
    chk({nm, "_err"}, 32'(erv), 32'(v.exp_err));
    chk({nm, "_busy_cycles"}, busy, v.busy);
    chk({nm, "_req_phases"}, phases, v.phases);
    chk({nm, "_req_cycles"}, reqcyc, v.reqcyc);
    chk({nm, "_writes"}, writes, v.nwr);
    chk({nm, "_mem_word"}, mem[wi], v.exp_word);
    if (v.rd && !v.wr) chk({nm, "_rdata"}, rdv, v.exp_rdata);
    if (v.phases > 0) begin
      chk({nm, "_mem_addr"}, 32'(fa), 32'(wi));
      chk({nm, "_mem_we"}, 32'(fw), 32'(v.wr && v.f3 == F3_W));
    end
  endtask

  vec_t vecs[20];
  int   dn, rq;
  logic found;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    //             rd wr f3     addr         wdata         init          dly   rdata         err busy ph rc wr word
    vecs[0]  = mk(1, 0, F3_W,  32'h10,  32'h0,        32'h8765_4321, 2,    32'h8765_4321, 0, 4,  1, 3, 0, 32'h8765_4321);
    vecs[1]  = mk(1, 0, F3_B,  32'h13,  32'h0,        32'h80FF_0000, 0,    32'hFFFF_FF80, 0, 2,  1, 1, 0, 32'h80FF_0000);
    vecs[2]  = mk(1, 0, F3_BU, 32'h13,  32'h0,        32'h80FF_0000, 0,    32'h0000_0080, 0, 2,  1, 1, 0, 32'h80FF_0000);
    vecs[3]  = mk(1, 0, F3_H,  32'h06,  32'h0,        32'h80FF_1234, 0,    32'hFFFF_80FF, 0, 2,  1, 1, 0, 32'h80FF_1234);
    vecs[4]  = mk(1, 0, F3_HU, 32'h06,  32'h0,        32'h80FF_1234, 0,    32'h0000_80FF, 0, 2,  1, 1, 0, 32'h80FF_1234);
    vecs[5]  = mk(1, 0, F3_B,  32'h10,  32'h0,        32'h0000_007F, 1,    32'h0000_007F, 0, 3,  1, 2, 0, 32'h0000_007F);
    vecs[6]  = mk(0, 1, F3_B,  32'h22,  32'h0000_00AB, 32'h1122_3344, 0,   32'h0,         0, 4,  2, 2, 1, 32'h11AB_3344);
    vecs[7]  = mk(0, 1, F3_H,  32'h2E,  32'hDEAD_BEEF, 32'h1122_3344, 1,   32'h0,         0, 6,  2, 4, 1, 32'hBEEF_3344);
    vecs[8]  = mk(0, 1, F3_W,  32'h30,  32'hCAFE_F00D, 32'h0,         0,   32'h0,         0, 2,  1, 1, 1, 32'hCAFE_F00D);
    vecs[9]  = mk(1, 0, F3_H,  32'h05,  32'h0,        32'h1111_2222, 0,    32'h0,         1, 1,  0, 0, 0, 32'h1111_2222);
    vecs[10] = mk(0, 1, F3_W,  32'h402, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 0,   32'h0,         2, 1,  0, 0, 0, 32'hA5A5_A5A5);
    vecs[11] = mk(1, 0, 3'b011, 32'h40, 32'h0,        32'h0,         0,    32'h0,         2, 1,  0, 0, 0, 32'h0);
    vecs[12] = mk(0, 1, F3_BU, 32'h44,  32'h77,       32'h0,         0,    32'h0,         2, 1,  0, 0, 0, 32'h0);
    vecs[13] = mk(1, 1, F3_W,  32'h08,  32'h1234,     32'h5555_AAAA, 0,    32'h0,         2, 1,  0, 0, 0, 32'h5555_AAAA);
    vecs[14] = mk(1, 0, F3_W,  32'h3FC, 32'h0,        32'h1357_9BDF, 0,    32'h1357_9BDF, 0, 2,  1, 1, 0, 32'h1357_9BDF);
    vecs[15] = mk(1, 0, F3_W,  32'h50,  32'h0,        32'h1234_5678, 1000, 32'h0,         3, 65, 1, 64, 0, 32'h1234_5678);
    vecs[16] = mk(0, 1, F3_H,  32'h54,  32'h0000_FFFF, 32'h0BAD_F00D, 1000, 32'h0,        3, 65, 1, 64, 0, 32'h0BAD_F00D);
    vecs[17] = mk(1, 0, F3_W,  32'h58,  32'h0,        32'h600D_CAFE, 63,   32'h600D_CAFE, 0, 65, 1, 64, 0, 32'h600D_CAFE);
    vecs[18] = mk(1, 0, F3_HU, 32'h03,  32'h0,        32'h0,         0,    32'h0,         1, 1,  0, 0, 0, 32'h0);
    vecs[19] = mk(1, 0, F3_W,  32'h12,  32'h0,        32'h0,         0,    32'h0,         1, 1,  0, 0, 0, 32'h0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_busy", 32'(cpu_busywait), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Acks while idle must not produce a completion.
    @(negedge clk) stray_ack = 1'b1;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (cpu_done) dn++;
    end
    stray_ack = 1'b0;
    repeat (2) begin @(negedge clk); #1; if (cpu_done) dn++; end
    chk("stray_ack_done", dn, 0);

    // Reset during the write phase of an SB: no done, no write.
    @(negedge clk);
    mem[9] = 32'h5566_7788; ack_delay = 4; writes = 0;
    cpu_write = 1'b1; cpu_func3 = F3_B; cpu_addr = 32'h24; cpu_wdata = 32'h99;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("rmw_wr_reached", 32'(found), 32'd1);
    reset = 1'b1; cpu_write = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_done", 32'(cpu_done), 32'd0);
    @(negedge clk) reset = 1'b0;
    dn = 0; rq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (cpu_done) dn++;
      if (mem_req) rq++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_no_req", rq, 0);
    chk("midrst_writes", writes, 0);
    chk("midrst_word", mem[9], 32'h5566_7788);

    // Controller still operates after the reset.
    run_vec(vecs[8], 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
